tempo_step_sequencer: RTL and testbench
=======================================

Name: tempo_step_sequencer

Overview:
- Consumes the slow 16 Hz square wave from the clock divider chain and converts it into a tempo-driven step address for the composer's note memory.
- Runs entirely in the CLOCK_50 domain; the divided clock is treated as data (synchronised and edge-detected), never used as a clock.
- Provides play/pause/stop control, a programmable number of 1/16 s ticks per step, loop or one-shot playback, and a one-cycle strobe per step for the downstream note player.

Parameters:
- ADDR_W, 5, width of step address; up to 2^ADDR_W steps.
- TPS_W, 4, width of ticks_per_step input.

Ports:
- CLOCK_50 input 1 system clock, 50 MHz.
- reset input 1 asynchronous, active-high reset.
- clock_16Hz input 1 16 Hz square wave from the divider; asynchronous to CLOCK_50 for design purposes.
- play input 1 level; start from IDLE/DONE, resume from PAUSE.
- pause input 1 level; RUN -> PAUSE.
- stop input 1 level; any state -> IDLE.
- loop_en input 1 1 = wrap at last_step, 0 = one-shot.
- ticks_per_step input TPS_W 16 Hz ticks per step; 0 treated as 1. Sampled at each step boundary.
- last_step input ADDR_W index of final step; sampled at start.
- step_addr output ADDR_W current step index.
- step_strobe output 1 one-cycle pulse when step_addr takes a new value to be played.
- playing output 1 high in RUN only.
- done output 1 one-cycle pulse on one-shot completion.

Behaviour:
- Reset (async, active-high): state = IDLE; step_addr = 0; step_strobe = 0; playing = 0; done = 0; tick counter = 0; synchroniser flops = 0.
- Tick detection: clock_16Hz passes through a 2-flop synchroniser and a third flop. tick = sync2 & ~sync3. Tick pulses 3 CLOCK_50 cycles after the input rise, one cycle wide, 16 per second.
- States:
  - IDLE: playing = 0.
    - play -> RUN: step_addr <= 0, tick_cnt <= 0, last_step latched, step_strobe pulses in the cycle after play is sampled.
  - RUN: playing = 1. Each tick increments tick_cnt. When tick_cnt == max(ticks_per_step,1)-1 on a tick:
    - tick_cnt <= 0.
    - If step_addr != latched last: step_addr +1, strobe.
    - Else if loop_en: step_addr <= 0, strobe.
    - Else: -> DONE, done pulses 1 cycle, step_addr holds, no strobe.
  - PAUSE: tick_cnt and step_addr frozen, ticks ignored, playing = 0.
    - play -> RUN with no strobe; the count continues from its frozen value.
  - DONE: playing = 0, step_addr holds.
    - play restarts exactly as from IDLE.
- Priority when simultaneous: stop > pause > play > tick.
  - stop in any state -> IDLE, step_addr <= 0, tick_cnt <= 0, no strobe, no done.
  - pause and a tick in the same cycle: the tick is discarded.
- last_step = 0: every step boundary wraps to 0 with a strobe (loop), or completes (one-shot).
- Arithmetic: step_addr is ADDR_W wide. Wrap is governed only by the latched last_step; natural overflow never occurs because last_step <= 2^ADDR_W-1.
- Reset mid-play: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: SEQ_METRONOME_EN.
- Defined:
  - Adds output port beat_pulse (1 bit).
  - Pulses one cycle coincident with step_strobe whenever the new step_addr[1:0] == 2'b00 (every 4th step, including the start step).
  - Held 0 in all other cycles and in reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic play: reset, ticks_per_step = 4, last_step = 3, loop_en = 1, pulse play.
  - Strobe with addr 0 the next cycle.
  - Then strobes with addr 1, 2, 3, 0 every 4 ticks (250 ms).
  - playing = 1 throughout.
- One-shot: loop_en = 0, last_step = 2, ticks_per_step = 1.
  - Strobes with addr 0, 1, 2.
  - On the next tick: done pulses once, playing -> 0, step_addr stays 2, no further strobes.
- Pause/resume: pause after 2 of 4 ticks within step 1; apply 10 ticks; resume.
  - No strobe on resume.
  - Step 2 strobes after exactly 2 further ticks.
- Priority: assert stop and tick in the same cycle while in RUN at addr 3.
  - -> IDLE, addr 0, no strobe, no done.
  - Repeat with pause + tick: tick discarded.
- ticks_per_step = 0 and last_step = 0 with loop: strobe on every tick with addr 0. Then assert async reset mid-cycle: all outputs 0 immediately, without waiting for a clock edge.
- SEQ_METRONOME_EN defined, last_step = 7, loop: beat_pulse coincides with the strobes for addr 0 and 4 only.

Source files
------------

// File: rtl/tempo_step_sequencer.sv
// tempo_step_sequencer: converts the 16 Hz divider square wave into a
// tempo-driven step address for the note memory, all in the CLOCK_50 domain.
//
// Ports:
//   CLOCK_50        system clock (50 MHz)
//   reset           asynchronous active-high reset
//   clock_16Hz      16 Hz square wave, treated as asynchronous data
//   play/pause/stop level controls (priority stop > pause > play > tick)
//   loop_en         1 = wrap after last_step, 0 = one-shot
//   ticks_per_step  16 Hz ticks per step (0 behaves as 1), taken at each step boundary
//   last_step       index of final step, taken at start
//   step_addr       current step index
//   step_strobe     one-cycle pulse when step_addr takes a new value to play
//   playing         high while running
//   done            one-cycle pulse on one-shot completion
//   beat_pulse      (only with SEQ_METRONOME_EN) strobe on steps with addr[1:0]==0
//
// Optional feature macro: SEQ_METRONOME_EN

module tempo_step_sequencer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned TPS_W  = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              clock_16Hz,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [TPS_W-1:0]  ticks_per_step,
  input  logic [ADDR_W-1:0] last_step,
  output logic [ADDR_W-1:0] step_addr,
  output logic              step_strobe,
  output logic              playing,
  output logic              done
`ifdef SEQ_METRONOME_EN
  ,
  output logic              beat_pulse
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_sync1, r_sync2, r_sync3;
  logic [TPS_W-1:0]  r_cnt;
  logic [TPS_W-1:0]  r_tps_m1;
  logic [ADDR_W-1:0] r_last;
  logic [ADDR_W-1:0] r_step_addr;
  logic              r_strobe;
  logic              r_playing;
  logic              r_done;

  state_t            w_nxt_state;
  logic [TPS_W-1:0]  w_nxt_cnt;
  logic [TPS_W-1:0]  w_nxt_tps_m1;
  logic [ADDR_W-1:0] w_nxt_last;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic              w_nxt_strobe;
  logic              w_nxt_done;
  logic              w_tick;
  logic [TPS_W-1:0]  w_tps_m1;

  // Synchroniser plus edge-detect flop for the divided clock
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= clock_16Hz;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_tick = r_sync2 & ~r_sync3;

  // Terminal count for a step; zero ticks per step behaves as one
  assign w_tps_m1 = (ticks_per_step == '0) ? '0 : ticks_per_step - TPS_W'(1);

  // Next-state and next-output logic
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    w_nxt_tps_m1 = r_tps_m1;
    w_nxt_last   = r_last;
    w_nxt_addr   = r_step_addr;
    w_nxt_strobe = 1'b0;
    w_nxt_done   = 1'b0;

    if (stop) begin
      w_nxt_state = S_IDLE;
      w_nxt_addr  = '0;
      w_nxt_cnt   = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (!pause && play) begin
            w_nxt_state  = S_RUN;
            w_nxt_addr   = '0;
            w_nxt_cnt    = '0;
            w_nxt_tps_m1 = w_tps_m1;
            w_nxt_last   = last_step;
            w_nxt_strobe = 1'b1;
          end
        end
        S_RUN: begin
          // Pause wins over a coincident tick, which is dropped
          if (pause) begin
            w_nxt_state = S_PAUSE;
          end else if (w_tick) begin
            if (r_cnt == r_tps_m1) begin
              w_nxt_cnt    = '0;
              w_nxt_tps_m1 = w_tps_m1;
              if (r_step_addr != r_last) begin
                w_nxt_addr   = r_step_addr + ADDR_W'(1);
                w_nxt_strobe = 1'b1;
              end else if (loop_en) begin
                w_nxt_addr   = '0;
                w_nxt_strobe = 1'b1;
              end else begin
                w_nxt_state = S_DONE;
                w_nxt_done  = 1'b1;
              end
            end else begin
              w_nxt_cnt = r_cnt + TPS_W'(1);
            end
          end
        end
        S_PAUSE: begin
          // Resume keeps the frozen count and does not re-strobe
          if (!pause && play) begin
            w_nxt_state = S_RUN;
          end
        end
        default: begin
          w_nxt_state = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tps_m1    <= '0;
      r_last      <= '0;
      r_step_addr <= '0;
      r_strobe    <= 1'b0;
      r_playing   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_tps_m1    <= w_nxt_tps_m1;
      r_last      <= w_nxt_last;
      r_step_addr <= w_nxt_addr;
      r_strobe    <= w_nxt_strobe;
      r_playing   <= (w_nxt_state == S_RUN);
      r_done      <= w_nxt_done;
    end
  end

  assign step_addr   = r_step_addr;
  assign step_strobe = r_strobe;
  assign playing     = r_playing;
  assign done        = r_done;

`ifdef SEQ_METRONOME_EN
  logic r_beat;

  // Beat marks every 4th step, including the start step
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_beat <= 1'b0;
    end else begin
      r_beat <= w_nxt_strobe & (w_nxt_addr[1:0] == 2'b00);
    end
  end

  assign beat_pulse = r_beat;
`endif

endmodule

// File: tb/tb_tempo_step_sequencer.sv
// Testbench for tempo_step_sequencer: directed scenarios plus randomized
// playback runs checked against a step-level reference model.

module tb_tempo_step_sequencer;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned TPS_W  = 4;

  logic              CLOCK_50;
  logic              reset;
  logic              clock_16Hz;
  logic              play;
  logic              pause;
  logic              stop;
  logic              loop_en;
  logic [TPS_W-1:0]  ticks_per_step;
  logic [ADDR_W-1:0] last_step;
  logic [ADDR_W-1:0] step_addr;
  logic              step_strobe;
  logic              playing;
  logic              done;
`ifdef SEQ_METRONOME_EN
  logic              beat_pulse;
`endif

  int checks = 0;
  int errors = 0;

  int log_q[$];
  int exp_q[$];
  int done_total = 0;
  int exp_done;
  int exp_play;
  int exp_addr;
`ifdef SEQ_METRONOME_EN
  int beat_q[$];
  int beat_orphan = 0;
`endif

  tempo_step_sequencer #(
    .ADDR_W(ADDR_W),
    .TPS_W (TPS_W)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .clock_16Hz    (clock_16Hz),
    .play          (play),
    .pause         (pause),
    .stop          (stop),
    .loop_en       (loop_en),
    .ticks_per_step(ticks_per_step),
    .last_step     (last_step),
    .step_addr     (step_addr),
    .step_strobe   (step_strobe),
    .playing       (playing),
    .done          (done)
`ifdef SEQ_METRONOME_EN
    ,
    .beat_pulse    (beat_pulse)
`endif
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Event log of strobes and done pulses, sampled mid-cycle
  always @(negedge CLOCK_50) begin
    if (step_strobe) log_q.push_back(int'(step_addr));
    if (done) done_total++;
`ifdef SEQ_METRONOME_EN
    if (beat_pulse) begin
      beat_q.push_back(int'(step_addr));
      if (!step_strobe) beat_orphan++;
    end
`endif
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_tick();
    clock_16Hz = 1'b1;
    wait_neg(4);
    clock_16Hz = 1'b0;
    wait_neg(4);
  endtask

  // Tick whose detection cycle coincides with stop (which==0) or pause (which==1)
  task automatic tick_with(input int which);
    clock_16Hz = 1'b1;
    wait_neg(2);
    if (which == 0) stop = 1'b1;
    else pause = 1'b1;
    wait_neg(1);
    stop  = 1'b0;
    pause = 1'b0;
    wait_neg(1);
    clock_16Hz = 1'b0;
    wait_neg(4);
  endtask

  task automatic pulse_play();
    play = 1'b1;
    wait_neg(1);
    play = 1'b0;
  endtask

  task automatic stop_seq();
    stop = 1'b1;
    wait_neg(1);
    stop = 1'b0;
    wait_neg(1);
  endtask

  function automatic bit q_match();
    if (log_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (log_q[i] != exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Step-level model: playback after n ticks from a fresh start
  task automatic model_run(input int t, input int l, input int lp, input int n);
    int te;
    int addr;
    bit running;
    te = (t == 0) ? 1 : t;
    exp_q.delete();
    exp_q.push_back(0);
    addr = 0;
    running = 1'b1;
    exp_done = 0;
    for (int b = 1; b <= n / te; b++) begin
      if (!running) break;
      if (addr != l) begin
        addr++;
        exp_q.push_back(addr);
      end else if (lp != 0) begin
        addr = 0;
        exp_q.push_back(addr);
      end else begin
        exp_done = 1;
        running = 1'b0;
      end
    end
    exp_play = running ? 1 : 0;
    exp_addr = addr;
  endtask

  task automatic setup(input int t, input int l, input int lp);
    ticks_per_step = TPS_W'(t);
    last_step      = ADDR_W'(l);
    loop_en        = lp[0];
    stop_seq();
    log_q.delete();
  endtask

  task automatic test_reset();
    checks++;
    if (step_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", step_addr); end
    checks++;
    if (step_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", step_strobe); end
    checks++;
    if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %b want 0", playing); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_basic_play();
    setup(4, 3, 1);
    pulse_play();
    checks++;
    if (step_strobe !== 1'b1 || step_addr !== '0) begin
      errors++; $display("FAIL basic_start: strobe=%b addr=%0d want strobe=1 addr=0", step_strobe, step_addr);
    end
    for (int i = 0; i < 16; i++) begin
      do_tick();
      checks++;
      if (playing !== 1'b1) begin errors++; $display("FAIL basic_playing tick %0d: got %b want 1", i, playing); end
    end
    exp_q = '{0, 1, 2, 3, 0};
    checks++;
    if (!q_match()) begin errors++; $display("FAIL basic_seq: got %p want %p", log_q, exp_q); end
  endtask

  task automatic test_one_shot();
    int d0;
    setup(1, 2, 0);
    d0 = done_total;
    pulse_play();
    for (int i = 0; i < 3; i++) do_tick();
    exp_q = '{0, 1, 2};
    checks++;
    if (!q_match()) begin errors++; $display("FAIL oneshot_seq: got %p want %p", log_q, exp_q); end
    checks++;
    if (done_total - d0 != 1) begin errors++; $display("FAIL oneshot_done: got %0d pulses want 1", done_total - d0); end
    checks++;
    if (playing !== 1'b0 || step_addr !== ADDR_W'(2)) begin
      errors++; $display("FAIL oneshot_end: playing=%b addr=%0d want 0/2", playing, step_addr);
    end
    do_tick();
    do_tick();
    checks++;
    if (!q_match() || done_total - d0 != 1) begin
      errors++; $display("FAIL oneshot_quiet: got %p done=%0d want %p done=1", log_q, done_total - d0, exp_q);
    end
  endtask

  task automatic test_pause_resume();
    setup(4, 3, 1);
    pulse_play();
    for (int i = 0; i < 6; i++) do_tick();
    pause = 1'b1;
    wait_neg(1);
    pause = 1'b0;
    checks++;
    if (playing !== 1'b0) begin errors++; $display("FAIL pause_playing: got %b want 0", playing); end
    for (int i = 0; i < 10; i++) do_tick();
    exp_q = '{0, 1};
    checks++;
    if (!q_match() || step_addr !== ADDR_W'(1)) begin
      errors++; $display("FAIL pause_frozen: got %p addr=%0d want %p addr=1", log_q, step_addr, exp_q);
    end
    pulse_play();
    checks++;
    if (step_strobe !== 1'b0 || playing !== 1'b1) begin
      errors++; $display("FAIL resume: strobe=%b playing=%b want 0/1", step_strobe, playing);
    end
    do_tick();
    checks++;
    if (!q_match()) begin errors++; $display("FAIL resume_early: got %p want %p", log_q, exp_q); end
    do_tick();
    exp_q = '{0, 1, 2};
    checks++;
    if (!q_match()) begin errors++; $display("FAIL resume_step: got %p want %p", log_q, exp_q); end
  endtask

  task automatic test_priority();
    int d0;
    setup(1, 7, 1);
    pulse_play();
    for (int i = 0; i < 3; i++) do_tick();
    checks++;
    if (step_addr !== ADDR_W'(3)) begin errors++; $display("FAIL prio_pre: addr=%0d want 3", step_addr); end
    d0 = done_total;
    tick_with(0);
    exp_q = '{0, 1, 2, 3};
    checks++;
    if (!q_match() || step_addr !== '0 || playing !== 1'b0 || done_total != d0) begin
      errors++; $display("FAIL prio_stop: got %p addr=%0d playing=%b done=%0d want %p addr=0 playing=0 done=0",
                        log_q, step_addr, playing, done_total - d0, exp_q);
    end
    setup(2, 7, 1);
    pulse_play();
    for (int i = 0; i < 3; i++) do_tick();
    tick_with(1);
    exp_q = '{0, 1};
    checks++;
    if (!q_match() || step_addr !== ADDR_W'(1) || playing !== 1'b0) begin
      errors++; $display("FAIL prio_pause: got %p addr=%0d playing=%b want %p addr=1 playing=0", log_q, step_addr, playing, exp_q);
    end
    pulse_play();
    do_tick();
    exp_q = '{0, 1, 2};
    checks++;
    if (!q_match()) begin errors++; $display("FAIL prio_pause_resume: got %p want %p", log_q, exp_q); end
  endtask

  task automatic test_tps_zero_and_reset();
    setup(0, 0, 1);
    pulse_play();
    for (int i = 0; i < 5; i++) do_tick();
    exp_q = '{0, 0, 0, 0, 0, 0};
    checks++;
    if (!q_match() || playing !== 1'b1) begin
      errors++; $display("FAIL tps0_seq: got %p playing=%b want %p playing=1", log_q, playing, exp_q);
    end
    // Reset asserted just after the edge that raises a strobe
    clock_16Hz = 1'b1;
    wait_neg(2);
    @(posedge CLOCK_50);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (step_strobe !== 1'b0 || playing !== 1'b0 || done !== 1'b0 || step_addr !== '0) begin
      errors++; $display("FAIL async_reset: strobe=%b playing=%b done=%b addr=%0d want all 0",
                        step_strobe, playing, done, step_addr);
    end
    clock_16Hz = 1'b0;
    wait_neg(2);
    reset = 1'b0;
    wait_neg(2);
  endtask

  task automatic test_random();
    int t, l, lp, n, te, d0;
    for (int it = 0; it < 10; it++) begin
      t  = int'($urandom_range(0, 4));
      l  = int'($urandom_range(0, 6));
      lp = int'($urandom_range(0, 1));
      te = (t == 0) ? 1 : t;
      n  = int'($urandom_range(0, te * (l + 2) + 2));
      setup(t, l, lp);
      d0 = done_total;
      model_run(t, l, lp, n);
      pulse_play();
      for (int i = 0; i < n; i++) do_tick();
      checks++;
      if (!q_match() || done_total - d0 != exp_done) begin
        errors++; $display("FAIL rand_seq it%0d t=%0d l=%0d lp=%0d n=%0d: got %p done=%0d want %p done=%0d",
                          it, t, l, lp, n, log_q, done_total - d0, exp_q, exp_done);
      end
      checks++;
      if (playing !== exp_play[0] || int'(step_addr) != exp_addr) begin
        errors++; $display("FAIL rand_state it%0d: playing=%b addr=%0d want %0d/%0d", it, playing, step_addr, exp_play, exp_addr);
      end
    end
  endtask

`ifdef SEQ_METRONOME_EN
  task automatic test_metronome();
    int expb[$];
    setup(1, 7, 1);
    beat_q.delete();
    pulse_play();
    for (int i = 0; i < 9; i++) do_tick();
    expb = '{0, 4, 0};
    checks++;
    if (beat_q != expb || beat_orphan != 0) begin
      errors++; $display("FAIL metronome: got %p orphan=%0d want %p orphan=0", beat_q, beat_orphan, expb);
    end
  endtask
`endif

  initial begin
    reset          = 1'b1;
    clock_16Hz     = 1'b0;
    play           = 1'b0;
    pause          = 1'b0;
    stop           = 1'b0;
    loop_en        = 1'b0;
    ticks_per_step = '0;
    last_step      = '0;
    wait_neg(3);
    test_reset();
    reset = 1'b0;
    wait_neg(2);
    test_reset();
    test_basic_play();
    test_one_shot();
    test_pause_resume();
    test_priority();
    test_tps_zero_and_reset();
    test_random();
`ifdef SEQ_METRONOME_EN
    test_metronome();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
